// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if: client request and controller command signals of the SDRAM request arbiter.
interface sdram_req_arbiter_if #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          wr_ready;
    logic                          rd_en;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic                          rd_ready;
    logic                          cmd_valid;
    logic                          cmd_we;
    logic [ADDR_WIDTH-1:0]         cmd_addr;
    logic [DATA_WIDTH-1:0]         cmd_data;
    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, busy,
        output wr_ready, rd_ready, cmd_valid, cmd_we, cmd_addr, cmd_data, fifo_level
    );
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, busy,
        input  wr_ready, rd_ready, cmd_valid, cmd_we, cmd_addr, cmd_data, fifo_level
    );
endinterface

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: arbitrates client writes/reads into an in-order command FIFO for the SDRAM controller.
// Define SDRAM_ARB_READ_PRIORITY_EN for fixed read priority on contention; otherwise grants alternate.
module sdram_req_arbiter #(
    parameter int ROW_WIDTH  = 12,
    parameter int COL_WIDTH  = 9,
    parameter int BANK_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    sdram_req_arbiter_if.slave bus
);
    localparam int ADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic                  we_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]         lvl_q, lvl_d;
    logic                  last_grant_q, last_grant_d;
    logic                  full, pick_wr, wr_fire, rd_fire, push, pop, valid;

`ifdef SDRAM_ARB_READ_PRIORITY_EN
    assign pick_wr = 1'b0;
`else
    assign pick_wr = ~last_grant_q;
`endif

    assign full    = lvl_q == LW'(FIFO_DEPTH);
    assign valid   = lvl_q != '0;
    assign wr_fire = ~reset & ~full & bus.wr_en & (~bus.rd_en | pick_wr);
    assign rd_fire = ~reset & ~full & bus.rd_en & ~wr_fire;
    assign push    = wr_fire | rd_fire;
    assign pop     = valid & ~bus.busy;

    always_comb begin
        wp_d         = push ? wp_q + PW'(1) : wp_q;
        rp_d         = pop ? rp_q + PW'(1) : rp_q;
        lvl_d        = lvl_q + LW'(push) - LW'(pop);
        last_grant_d = push ? wr_fire : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q         <= '0;
            rp_q         <= '0;
            lvl_q        <= '0;
            last_grant_q <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            lvl_q        <= lvl_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Reads store zero data so the head needs no extra masking by type
    always_ff @(posedge clk) begin
        if (push) begin
            we_q[wp_q]   <= wr_fire;
            addr_q[wp_q] <= wr_fire ? bus.wr_addr : bus.rd_addr;
            data_q[wp_q] <= wr_fire ? bus.wr_data : '0;
        end
    end

    assign bus.wr_ready   = wr_fire;
    assign bus.rd_ready   = rd_fire;
    assign bus.cmd_valid  = valid;
    assign bus.cmd_we     = valid & we_q[rp_q];
    assign bus.cmd_addr   = valid ? addr_q[rp_q] : '0;
    assign bus.cmd_data   = valid ? data_q[rp_q] : '0;
    assign bus.fifo_level = lvl_q;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter: directed stimulus with a scoreboard queue checked by an independent command monitor.
module tb_sdram_req_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    cmd_t exp_q[$];
    cmd_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [3:0] gsel;
    int   wi, ri;

    always #5 clk = ~clk;

    sdram_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) bus();
    sdram_req_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic w, input logic r, input logic [AW-1:0] wa,
                       input logic [AW-1:0] ra, input logic [DW-1:0] wd, input logic b,
                       input logic ew, input logic er);
        @(negedge clk);
        reset       = rst;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.wr_addr = wa;
        bus.rd_addr = ra;
        bus.wr_data = wd;
        bus.busy    = b;
        if (rst) exp_q.delete();
        #1;
        chk("wr_ready", bus.wr_ready, ew);
        chk("rd_ready", bus.rd_ready, er);
        if (ew) exp_q.push_back({1'b1, wa, wd});
        if (er) exp_q.push_back({1'b0, ra, 32'h0});
    endtask

    task automatic idle(input logic b);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, b, 1'b0, 1'b0);
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        if (!reset && bus.cmd_valid && !bus.busy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_cmd: got addr %0h expected no command", bus.cmd_addr);
            end else begin
                e = exp_q.pop_front();
                chk("mon_cmd_we", bus.cmd_we, e.we);
                chk("mon_cmd_addr", bus.cmd_addr, e.addr);
                chk("mon_cmd_data", bus.cmd_data, e.data);
            end
        end
    end

    initial begin
        bus.wr_en = 0; bus.rd_en = 0; bus.wr_addr = '0; bus.rd_addr = '0;
        bus.wr_data = '0; bus.busy = 0;
        // requests during reset are never accepted
        cyc(1, 1, 1, 23'h1, 23'h2, 32'h5, 0, 0, 0);
        cyc(1, 0, 0, '0, '0, '0, 0, 0, 0);
        idle(0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd_we", bus.cmd_we, 0);
        chk("rst_cmd_addr", bus.cmd_addr, 0);
        chk("rst_cmd_data", bus.cmd_data, 0);
        chk("rst_level", bus.fifo_level, 0);
        // single write, one-cycle latency
        cyc(0, 1, 0, 23'h000123, '0, 32'hDEADBEEF, 0, 1, 0);
        idle(0);
        chk("w1_cmd_valid", bus.cmd_valid, 1);
        chk("w1_cmd_we", bus.cmd_we, 1);
        chk("w1_cmd_addr", bus.cmd_addr, 23'h000123);
        chk("w1_cmd_data", bus.cmd_data, 32'hDEADBEEF);
        chk("w1_level", bus.fifo_level, 1);
        idle(0);
        chk("w1_level_drained", bus.fifo_level, 0);
        chk("w1_valid_drained", bus.cmd_valid, 0);
        // fill while busy; full blocks even with a same-cycle pop
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 23'h100 + i, '0, 32'hA0000000 + i, 1, 1, 0);
        cyc(0, 1, 0, 23'h1FF, '0, 32'hBAD, 0, 0, 0);
        chk("full_level", bus.fifo_level, 4);
        repeat (4) idle(0);
        chk("full_drained", bus.fifo_level, 0);
        // contention arbitration
        cyc(1, 0, 0, '0, '0, '0, 1, 0, 0);
`ifdef SDRAM_ARB_READ_PRIORITY_EN
        gsel = 4'b1100;
`else
        gsel = 4'b0101;
`endif
        wi = 0; ri = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, wi < 2, ri < 2, 23'h200 + wi, 23'h300 + ri, 32'hC0 + wi, 1, gsel[i], !gsel[i]);
            if (gsel[i]) wi++; else ri++;
        end
        idle(0);
        chk("arb_level", bus.fifo_level, 4);
        repeat (4) idle(0);
        chk("arb_drained", bus.fifo_level, 0);
        // simultaneous push and pop
        cyc(0, 1, 0, 23'h400, '0, 32'h44, 1, 1, 0);
        cyc(0, 0, 1, '0, 23'h401, '0, 1, 0, 1);
        cyc(0, 1, 0, 23'h402, '0, 32'h46, 0, 1, 0);
        chk("pp_level_before", bus.fifo_level, 2);
        idle(0);
        chk("pp_level_after", bus.fifo_level, 2);
        idle(0);
        idle(0);
        chk("pp_drained", bus.fifo_level, 0);
        // reset mid-traffic discards queued commands
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 23'h500 + i, '0, 32'h50 + i, 1, 1, 0);
        idle(1);
        chk("mid_level", bus.fifo_level, 3);
        cyc(1, 1, 0, 23'h5FF, '0, 32'hFF, 0, 0, 0);
        idle(0);
        chk("mid_rst_valid", bus.cmd_valid, 0);
        chk("mid_rst_level", bus.fifo_level, 0);
        repeat (3) idle(0);
        chk("empty_busy_low_valid", bus.cmd_valid, 0);
        chk("empty_busy_low_level", bus.fifo_level, 0);
        cyc(0, 1, 0, 23'h600, '0, 32'h66, 0, 1, 0);
        idle(0);
        idle(0);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_req_arbiter.md
SDRAM_REQ_ARBITER -- requirements
Module: sdram_req_arbiter

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 12, SDRAM row address bits.
REQ-002 SHALL have parameter COL_WIDTH, default 9, SDRAM column address bits.
REQ-003 SHALL have parameter BANK_WIDTH, default 2, SDRAM bank address bits.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, data word bits.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, command queue entries; power of two, at least 2.
REQ-006 SHALL define localparam ADDR_WIDTH = BANK_WIDTH+ROW_WIDTH+COL_WIDTH (23 at defaults).
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port wr_en, input, 1, client write request.
REQ-010 SHALL have port wr_addr, input, ADDR_WIDTH, write address {bank,row,col}.
REQ-011 SHALL have port wr_data, input, DATA_WIDTH, write data.
REQ-012 SHALL have port wr_ready, output, 1, write request accepted this cycle when high with wr_en.
REQ-013 SHALL have port rd_en, input, 1, client read request.
REQ-014 SHALL have port rd_addr, input, ADDR_WIDTH, read address {bank,row,col}.
REQ-015 SHALL have port rd_ready, output, 1, read request accepted this cycle when high with rd_en.
REQ-016 SHALL have port cmd_valid, output, 1, queue head valid toward sdram_controller.
REQ-017 SHALL have port cmd_we, output, 1, head is write (1) or read (0).
REQ-018 SHALL have port cmd_addr, output, ADDR_WIDTH, head address.
REQ-019 SHALL have port cmd_data, output, DATA_WIDTH, head write data; all zeros for reads.
REQ-020 SHALL have port busy, input, 1, controller busy; head consumed on a cycle with cmd_valid=1 and busy=0.
REQ-021 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current entry count.

Function
REQ-022 SHALL hold requests in a FIFO of FIFO_DEPTH entries {we, addr, data}; wr/rd pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL drive wr_ready and rd_ready combinationally: low when full; at most one high per cycle.
REQ-024 SHALL, with only one of wr_en/rd_en high and not full, assert that port's ready.
REQ-025 SHALL, with both high and not full, grant per arbitration policy (REQ-036); the loser's ready low, loser must hold request.
REQ-026 SHALL register last_grant on every accepted request (1 = write).
REQ-027 SHALL drive cmd_valid = (fifo_level != 0) and cmd_we/cmd_addr/cmd_data from the head entry, stable while busy=1.
REQ-028 SHALL impose 1-cycle minimum latency: request accepted at edge N appears on cmd_* after edge N; no combinational bypass.
REQ-029 SHALL preserve acceptance order across reads and writes (no reordering).
REQ-030 SHALL keep fifo_level unchanged on simultaneous push and pop; +1 push only; -1 pop only.
REQ-031 SHALL, when full, deassert both readies even if a pop occurs that cycle.
REQ-032 SHALL ignore busy when cmd_valid=0 (no pop, no underflow).

Reset
REQ-033 SHALL on reset=1 at a clk edge clear pointers and fifo_level to 0, set last_grant to 0 (read), discarding all queued entries.
REQ-034 SHALL after reset drive cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_data=0, fifo_level=0; readies low while reset=1.
REQ-035 SHALL give reset priority over simultaneous push/pop; a request presented during reset is not accepted.

Configuration
REQ-036 SHALL, with macro SDRAM_ARB_READ_PRIORITY_EN defined, always grant read on contention; without it, alternate: grant the port opposite last_grant (first contention after reset goes to write).

Verification
REQ-037 Reset, then wr_en=1 addr 0x000123 data 0xDEADBEEF, busy=0 -> wr_ready=1; next cycle cmd_valid=1, cmd_we=1, cmd_addr=0x000123, cmd_data=0xDEADBEEF; one cycle later fifo_level=0.
REQ-038 busy=1, push 4 writes -> fifo_level=4, wr_ready=0 on 5th; release busy -> 4 commands in order, 1 per cycle.
REQ-039 wr_en and rd_en held high 4 cycles after reset, macro off -> grants W,R,W,R; macro on -> R,R then W,W.
REQ-040 Level 2, push and pop same cycle -> fifo_level stays 2, order intact.
REQ-041 Level 3, assert reset one cycle mid-traffic -> next cycle cmd_valid=0, fifo_level=0, no stale command issued.
